// File: rtl/hazard_detect.sv
// hazard_detect: per-stage stall request generator for the 5-stage pipeline.
// Combines instruction-fetch wait, load-use, multi-cycle mul/div occupancy and
// data-memory wait into a {F,D,X,M,W} stall request vector, and keeps a
// stall-cycle counter plus a sticky data-memory timeout flag.
module hazard_detect #(
  parameter int MDIV_LAT    = 4,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             f_imem_ready,
  input  logic [4:0]       d_rs1,
  input  logic [4:0]       d_rs2,
  input  logic             d_use_rs1,
  input  logic             d_use_rs2,
  input  logic [4:0]       x_rd,
  input  logic             x_mem_read,
  input  logic             x_mdiv_start,
  input  logic             m_mem_req,
  input  logic             m_mem_ready,
  output logic [4:0]       stall_req,
  output logic             mdiv_done,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int MW = $clog2(MDIV_LAT + 1);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [MW-1:0] MDIV_LOAD = MW'(MDIV_LAT - 1);
  localparam logic [MW-1:0] MDIV_ONE  = MW'(1);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(MEM_TIMEOUT);
  localparam logic [WW-1:0] WAIT_ONE  = WW'(1);

  logic [MW-1:0]    mdiv_cnt_q, mdiv_cnt_d;
  logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic       stall_f, stall_d, stall_x, stall_m;
  logic       mdiv_accept;
  logic       mdiv_done_raw;
  logic [4:0] stall_vec;

  // Stall sources and next-state computation for all counters.
  always_comb begin
    stall_f = ~f_imem_ready;

    // A load in X whose destination is read by D; x0 never creates a hazard.
    stall_d = x_mem_read && (x_rd != 5'd0) &&
              ((d_use_rs1 && (d_rs1 == x_rd)) || (d_use_rs2 && (d_rs2 == x_rd)));

    // A new op is only accepted when the unit is idle; while busy, a held
    // x_mdiv_start is the same op and is ignored.
    mdiv_accept = x_mdiv_start && (mdiv_cnt_q == '0) && (MDIV_LAT > 1);
    stall_x     = mdiv_accept || (mdiv_cnt_q > MDIV_ONE);
    if (MDIV_LAT == 1) mdiv_done_raw = x_mdiv_start;
    else               mdiv_done_raw = (mdiv_cnt_q == MDIV_ONE);

    // The unit keeps counting even if X is frozen by a downstream stall.
    mdiv_cnt_d = mdiv_cnt_q;
    if (mdiv_accept)             mdiv_cnt_d = MDIV_LOAD;
    else if (mdiv_cnt_q != '0)   mdiv_cnt_d = mdiv_cnt_q - MDIV_ONE;

    stall_m   = m_mem_req && !m_mem_ready;
    stall_vec = {stall_f, stall_d, stall_x, stall_m, 1'b0};

    wait_cnt_d = '0;
    if (stall_m) wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WAIT_ONE;

    mem_timeout_d  = mem_timeout_q || (stall_m && (wait_cnt_d == WAIT_MAX));
    stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, (stall_vec != 5'd0)};
  end

  // State registers; reset aborts any mul/div op or memory wait in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdiv_cnt_q     <= '0;
      wait_cnt_q     <= '0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      mdiv_cnt_q     <= mdiv_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // Combinational outputs are held quiet while reset is asserted.
  always_comb begin
    stall_req    = rst_n ? stall_vec : 5'd0;
    mdiv_done    = rst_n && mdiv_done_raw;
    mem_timeout  = mem_timeout_q;
    stall_cycles = stall_cycles_q;
  end

endmodule

// File: tb/tb_hazard_detect.sv
// Directed testbench for hazard_detect (MDIV_LAT=4, MEM_TIMEOUT=4, CNT_W=32).
module tb_hazard_detect;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_imem_ready;
  logic [4:0]  d_rs1, d_rs2, x_rd;
  logic        d_use_rs1, d_use_rs2;
  logic        x_mem_read, x_mdiv_start;
  logic        m_mem_req, m_mem_ready;
  logic [4:0]  stall_req;
  logic        mdiv_done;
  logic        mem_timeout;
  logic [31:0] stall_cycles;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_sc   = 0;

  always #5 clk = ~clk;

  hazard_detect #(.MDIV_LAT(4), .MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .f_imem_ready(f_imem_ready),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2),
    .x_rd(x_rd), .x_mem_read(x_mem_read), .x_mdiv_start(x_mdiv_start),
    .m_mem_req(m_mem_req), .m_mem_ready(m_mem_ready),
    .stall_req(stall_req), .mdiv_done(mdiv_done), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One pipeline cycle: check combinational outputs mid-cycle, then clock.
  task automatic cyc(input string tag, input logic [4:0] exp_stall, input logic exp_done);
    #1;
    chk({tag, ".stall"}, 32'(stall_req), 32'(exp_stall));
    chk({tag, ".done"},  32'(mdiv_done), 32'(exp_done));
    $display("cycle %s stall_req=%05b mdiv_done=%0b", tag, stall_req, mdiv_done);
    if (exp_stall != 5'd0) exp_sc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; f_imem_ready = 1'b0;
    d_rs1 = 5'd0; d_rs2 = 5'd0; x_rd = 5'd0;
    d_use_rs1 = 1'b0; d_use_rs2 = 1'b0;
    x_mem_read = 1'b0; x_mdiv_start = 1'b0;
    m_mem_req = 1'b0; m_mem_ready = 1'b0;

    // Reset: outputs forced quiet even with fetch waiting.
    repeat (2) @(posedge clk);
    #1;
    chk("rst.stall", 32'(stall_req), 32'd0);
    chk("rst.done", 32'(mdiv_done), 32'd0);
    chk("rst.timeout", 32'(mem_timeout), 32'd0);
    chk("rst.cycles", stall_cycles, 32'd0);
    f_imem_ready = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Load-use on rs2, x0 destination, load-use on rs1, unused source.
    x_mem_read = 1'b1; x_rd = 5'd5; d_rs2 = 5'd5; d_use_rs2 = 1'b1;
    cyc("lu_rs2", 5'b01000, 1'b0);
    x_rd = 5'd0; d_rs2 = 5'd0;
    cyc("lu_x0", 5'b00000, 1'b0);
    x_rd = 5'd7; d_rs1 = 5'd7; d_use_rs1 = 1'b1; d_use_rs2 = 1'b0;
    cyc("lu_rs1", 5'b01000, 1'b0);
    d_use_rs1 = 1'b0;
    cyc("lu_nouse", 5'b00000, 1'b0);
    x_mem_read = 1'b0;
    chk("lu.cycles", stall_cycles, 32'(exp_sc));

    // Mul/div occupying X for 4 cycles.
    x_mdiv_start = 1'b1;
    cyc("md1", 5'b00100, 1'b0);
    cyc("md2", 5'b00100, 1'b0);
    cyc("md3", 5'b00100, 1'b0);
    cyc("md4", 5'b00000, 1'b1);
    x_mdiv_start = 1'b0;
    chk("md.cycles", stall_cycles, 32'(exp_sc));

    // M wait 3 cycles, twice: no timeout because the count clears in between.
    m_mem_req = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m_mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) cyc("mw", 5'b00010, 1'b0);
      m_mem_ready = 1'b1;
      cyc("mw_rdy", 5'b00000, 1'b0);
      chk("mw.timeout", 32'(mem_timeout), 32'd0);
    end
    m_mem_req = 1'b0;
    chk("mw.cycles", stall_cycles, 32'(exp_sc));

    // 10-cycle M wait: timeout rises after the 4th wait cycle and sticks.
    m_mem_req = 1'b1; m_mem_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cyc("to", 5'b00010, 1'b0);
      chk("to.timeout", 32'(mem_timeout), (k >= 4) ? 32'd1 : 32'd0);
    end
    m_mem_ready = 1'b1;
    cyc("to_rdy", 5'b00000, 1'b0);
    m_mem_req = 1'b0;
    cyc("to_idle", 5'b00000, 1'b0);
    chk("to.sticky", 32'(mem_timeout), 32'd1);

    // Simultaneous fetch wait, mul/div busy and M wait.
    x_mdiv_start = 1'b1;
    cyc("sim0", 5'b00100, 1'b0);
    f_imem_ready = 1'b0; m_mem_req = 1'b1; m_mem_ready = 1'b0;
    cyc("sim1", 5'b10110, 1'b0);
    cyc("sim2", 5'b10110, 1'b0);
    cyc("sim3", 5'b10010, 1'b1);
    x_mdiv_start = 1'b0;
    cyc("sim4", 5'b10010, 1'b0);
    f_imem_ready = 1'b1; m_mem_req = 1'b0; m_mem_ready = 1'b1;
    chk("sim.cycles", stall_cycles, 32'(exp_sc));

    // Reset in the middle of a mul/div op and an M wait.
    x_mdiv_start = 1'b1;
    cyc("ar0", 5'b00100, 1'b0);
    m_mem_req = 1'b1; m_mem_ready = 1'b0;
    cyc("ar1", 5'b00110, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("ar.stall", 32'(stall_req), 32'd0);
    chk("ar.done", 32'(mdiv_done), 32'd0);
    chk("ar.timeout", 32'(mem_timeout), 32'd0);
    chk("ar.cycles", stall_cycles, 32'd0);
    @(posedge clk); #1;
    chk("ar.held", stall_cycles, 32'd0);
    x_mdiv_start = 1'b0; m_mem_req = 1'b0; m_mem_ready = 1'b1;
    rst_n = 1'b1;
    exp_sc = 0;
    @(posedge clk); #1;
    x_mdiv_start = 1'b1;
    cyc("re1", 5'b00100, 1'b0);
    cyc("re2", 5'b00100, 1'b0);
    cyc("re3", 5'b00100, 1'b0);
    cyc("re4", 5'b00000, 1'b1);
    x_mdiv_start = 1'b0;
    cyc("re5", 5'b00000, 1'b0);
    chk("re.cycles", stall_cycles, 32'(exp_sc));
    chk("re.timeout", 32'(mem_timeout), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
